seg_scan_driver: RTL

//  Downstream display stage for the 3-digit BCD counter. Takes the counter's three

---
 rtl/seg_scan_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes three active-low 7-segment codes from the
// BCD counter onto one shared segment bus with per-digit enables, adding
// leading-zero blanking, anti-ghost dead time and overflow blinking.
module seg_scan_driver #(
   parameter int SCAN_DIV   = 50000,
   parameter int DEAD       = 4,
   parameter int BLINK_HALF = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg0_in,
   input  logic [6:0] seg1_in,
   input  logic [6:0] seg2_in,
   input  logic       ovf_in,
   input  logic       blink_en,
   output logic [6:0] seg_out,
   output logic [2:0] dig_sel,
   output logic       frame_tick
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLK_W = $clog2(BLINK_HALF + 1);

   localparam logic [6:0] CODE_ZERO = 7'b1000000;
   localparam logic [6:0] CODE_DARK = 7'h7F;

   typedef enum logic [1:0] {
      SLOT_UNITS    = 2'd0,
      SLOT_TENS     = 2'd1,
      SLOT_HUNDREDS = 2'd2
   } slot_t;

   slot_t             slot_q, slot_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [6:0]        code0_q, code0_d;
   logic [6:0]        code1_q, code1_d;
   logic [6:0]        code2_q, code2_d;
   logic              ovf_q, ovf_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;
   logic [6:0]        seg_out_q, seg_out_d;
   logic [2:0]        dig_sel_q, dig_sel_d;
   logic              frame_tick_q, frame_tick_d;

   logic              frame_start;
   logic              blink_active;
   logic              hund_blank;
   logic              tens_blank;
   logic              digit_blank;
   logic [6:0]        digit_code;

   // Only an exact '0' pattern counts as zero; any other code is displayed as-is.
   function automatic logic is_zero(input logic [6:0] code);
      return code == CODE_ZERO;
   endfunction

   // Slot sequencing, frame-start latching and blink phase tracking.
   always_comb begin
      div_cnt_d    = div_cnt_q + DIV_W'(1);
      slot_d       = slot_q;
      frame_start  = (slot_q == SLOT_UNITS) && (div_cnt_q == '0);
      blink_active = ovf_q && blink_en;

      if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
         div_cnt_d = '0;
         case (slot_q)
            SLOT_UNITS: slot_d = SLOT_TENS;
            SLOT_TENS:  slot_d = SLOT_HUNDREDS;
            default:    slot_d = SLOT_UNITS;
         endcase
      end

      code0_d      = code0_q;
      code1_d      = code1_q;
      code2_d      = code2_q;
      ovf_d        = ovf_q;
      frame_tick_d = frame_start;
      if (frame_start) begin
         code0_d = seg0_in;
         code1_d = seg1_in;
         code2_d = seg2_in;
         ovf_d   = ovf_in;
      end

      // An idle blinker is parked at count 0 / ON so every episode begins lit.
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (!blink_active) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (frame_start) begin
         if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
         end
      end
   end

   // Output decode for the current slot; registered so the buses are glitch-free.
   always_comb begin
      hund_blank = is_zero(code2_q);
      tens_blank = hund_blank && is_zero(code1_q);

      digit_code  = CODE_DARK;
      digit_blank = 1'b1;
      case (slot_q)
         SLOT_UNITS: begin
            digit_code  = code0_q;
            digit_blank = 1'b0;
         end
         SLOT_TENS: begin
            digit_code  = code1_q;
            digit_blank = tens_blank;
         end
         SLOT_HUNDREDS: begin
            digit_code  = code2_q;
            digit_blank = hund_blank;
         end
         default: begin
            digit_code  = CODE_DARK;
            digit_blank = 1'b1;
         end
      endcase

      seg_out_d = CODE_DARK;
      dig_sel_d = 3'b111;
      if (!((div_cnt_q < DIV_W'(DEAD)) || digit_blank || (blink_active && !blink_on_q))) begin
         seg_out_d = digit_code;
         dig_sel_d = ~(3'b001 << slot_q);
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q       <= SLOT_UNITS;
         div_cnt_q    <= '0;
         code0_q      <= CODE_DARK;
         code1_q      <= CODE_DARK;
         code2_q      <= CODE_DARK;
         ovf_q        <= 1'b0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b1;
         seg_out_q    <= CODE_DARK;
         dig_sel_q    <= 3'b111;
         frame_tick_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         div_cnt_q    <= div_cnt_d;
         code0_q      <= code0_d;
         code1_q      <= code1_d;
         code2_q      <= code2_d;
         ovf_q        <= ovf_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_on_q   <= blink_on_d;
         seg_out_q    <= seg_out_d;
         dig_sel_q    <= dig_sel_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg_out    = seg_out_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = frame_tick_q;

endmodule
